// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_tx parallel-in/serial-out transmitter.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } piso_state_e;

  // Bit counter width for a DW-bit word; DW >= 2 keeps this at least 1.
  function automatic int cnt_width(input int dw);
    return (dw < 2) ? 1 : $clog2(dw);
  endfunction

endpackage

// File: rtl/piso_tx_if.sv
// Handshake and serial-output bundle between upstream, piso_tx and the SIPO stage.
interface piso_tx_if #(
  parameter int DW = 4
);

  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          o_ready;
  logic          o_ser;
  logic          o_enb;
  logic          o_done;

  // Upstream word source plus downstream observer of the serial stream.
  modport master (
    output i_valid, i_data,
    input  o_ready, o_ser, o_enb, o_done
  );

  // The transmitter itself.
  modport slave (
    input  i_valid, i_data,
    output o_ready, o_ser, o_enb, o_done
  );

endinterface

// File: rtl/piso_shreg.sv
// DW-bit loadable right-shift register; bit 0 is the next serial bit out.
module piso_shreg #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          shift,
  input  logic [DW-1:0] d,
  output logic          q_lsb
);

  logic [DW-1:0] sr_q;
  logic [DW-1:0] sr_d;

  // Next value: load wins over shift; zero fills the MSB while shifting.
  always_comb begin
    // NOTE: default assignment first so every path drives sr_d and no latch is inferred.
    sr_d = sr_q;
    if (load) begin
      sr_d = d;
    end else if (shift) begin
      sr_d = {1'b0, sr_q[DW-1:1]};
    end
  end

  // Register; reset clears any partially transmitted word.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments for flops so all state updates see pre-edge values.
    if (!rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q_lsb = sr_q[0];

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: accepts a word on valid/ready, emits it
// LSB first with o_enb framing, then pulses o_done for one cycle.
module piso_tx
  import piso_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic      clk,
  input  logic      rst,
  piso_tx_if.slave  bus
);

  localparam int                CNT_W    = cnt_width(DW);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DW - 1);

  piso_state_e      state_q;
  piso_state_e      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             load;
  logic             shift;
  logic             q_lsb;

  piso_shreg #(
    .DW (DW)
  ) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .d     (bus.i_data),
    .q_lsb (q_lsb)
  );

  // Next-state, counter and shift-register control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Park the counter at zero rather than letting it wrap.
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers; reset abandons any word in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore outputs decoded from registered state and the shift register.
  always_comb begin
    bus.o_ready = (state_q == IDLE);
    bus.o_enb   = (state_q == SHIFT);
    bus.o_done  = (state_q == DONE);
    bus.o_ser   = (state_q == SHIFT) && q_lsb;
  end

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx at DW=4 and DW=8, each feeding a SIPO model.
// Expected outputs follow from the cycle offset since each accepted handshake.
module tb_piso_tx;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  piso_tx_if #(.DW(4)) if4 ();
  piso_tx_if #(.DW(8)) if8 ();

  piso_tx #(.DW(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
  piso_tx #(.DW(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

  // Downstream SIPO: loads at the MSB and shifts right on each enabled edge.
  logic [3:0] sipo4 = '0;
  logic [7:0] sipo8 = '0;
  always @(posedge clk) begin
    if (if4.o_enb) sipo4 <= {if4.o_ser, sipo4[3:1]};
    if (if8.o_enb) sipo8 <= {if8.o_ser, sipo8[7:1]};
  end

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Reference model: per DUT, whether a word is in flight, the edge index of
  // its handshake and the word itself.
  bit         inflight [2];
  int         hs       [2];
  logic [7:0] word     [2];
  int         dwv      [2];
  bit         dummy;

  function automatic bit model_ready(input int d);
    return !inflight[d] || ((cyc - hs[d]) >= dwv[d] + 1);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int d);
    logic       r, s, e, dn;
    logic [7:0] sp;
    string      p;
    int         off;
    logic       er, es, ee, ed;
    if (d == 0) begin
      r = if4.o_ready; s = if4.o_ser; e = if4.o_enb; dn = if4.o_done;
      sp = {4'b0, sipo4}; p = "dw4";
    end else begin
      r = if8.o_ready; s = if8.o_ser; e = if8.o_enb; dn = if8.o_done;
      sp = sipo8; p = "dw8";
    end
    off = cyc - hs[d];
    er  = model_ready(d);
    ee  = inflight[d] && (off >= 0) && (off < dwv[d]);
    es  = ee ? word[d][off] : 1'b0;
    ed  = inflight[d] && (off == dwv[d]);
    check($sformatf("%s_ready_c%0d", p, cyc), {7'b0, r},  {7'b0, er});
    check($sformatf("%s_enb_c%0d",   p, cyc), {7'b0, e},  {7'b0, ee});
    check($sformatf("%s_ser_c%0d",   p, cyc), {7'b0, s},  {7'b0, es});
    check($sformatf("%s_done_c%0d",  p, cyc), {7'b0, dn}, {7'b0, ed});
    if (ed) check($sformatf("%s_sipo_c%0d", p, cyc), sp, word[d]);
  endtask

  // One clock cycle: drive inputs, predict handshakes, clock, then check both DUTs.
  task automatic step(input int d, input bit v, input logic [7:0] data, output bit acc);
    logic [7:0] r4, r8;
    bit         pend [2];
    logic [7:0] w    [2];
    r4 = 8'($urandom);
    r8 = 8'($urandom);
    if4.i_valid = (d == 0) && v;
    if4.i_data  = (d == 0) ? data[3:0] : r4[3:0];
    if8.i_valid = (d == 1) && v;
    if8.i_data  = (d == 1) ? data : r8;
    pend[0] = model_ready(0) && if4.i_valid;
    pend[1] = model_ready(1) && if8.i_valid;
    w[0]    = {4'b0, if4.i_data};
    w[1]    = if8.i_data;
    @(posedge clk);
    cyc++;
    for (int x = 0; x < 2; x++) begin
      if (pend[x]) begin
        inflight[x] = 1'b1;
        hs[x]       = cyc;
        word[x]     = w[x];
      end
    end
    acc = pend[d];
    @(negedge clk);
    check_dut(0);
    check_dut(1);
  endtask

  task automatic flush(input int d, input int n);
    bit a;
    for (int i = 0; i < n; i++) step(d, 1'b0, 8'($urandom), a);
  endtask

  // Called at a falling edge: assert reset between edges, check the outputs
  // respond without a clock, hold across one edge, release at the next fall.
  task automatic pulse_reset();
    if4.i_valid = 1'b0;
    if8.i_valid = 1'b0;
    #2 rst = 1'b0;
    inflight[0] = 1'b0;
    inflight[1] = 1'b0;
    #1;
    check_dut(0);
    check_dut(1);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    rst = 1'b1;
  endtask

  initial begin
    dwv[0] = 4;  dwv[1] = 8;
    inflight[0] = 1'b0; inflight[1] = 1'b0;
    hs[0] = 0; hs[1] = 0;
    word[0] = '0; word[1] = '0;
    rst = 1'b0;
    if4.i_valid = 1'b0; if4.i_data = '0;
    if8.i_valid = 1'b0; if8.i_data = '0;

    // Reset state, then release so the very next edge may handshake.
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    rst = 1'b1;

    // Single word 4'b1011.
    step(0, 1'b1, 8'h0B, dummy);
    flush(0, 6);

    // Back-to-back: hold valid with 4'hA then 4'h3.
    step(0, 1'b1, 8'h0A, dummy);
    for (int i = 0; i < 20; i++) begin
      step(0, 1'b1, 8'h03, dummy);
      if (dummy) break;
    end
    flush(0, 7);

    // Busy ignore: 4'hF offered while 4'hC is shifting.
    step(0, 1'b1, 8'h0C, dummy);
    step(0, 1'b0, 8'h0F, dummy);
    step(0, 1'b1, 8'h0F, dummy);
    step(0, 1'b0, 8'h0F, dummy);
    flush(0, 6);

    // Reset mid-shift of 4'b0110, then 4'b1001 transmits cleanly.
    step(0, 1'b1, 8'h06, dummy);
    step(0, 1'b0, 8'h00, dummy);
    pulse_reset();
    step(0, 1'b1, 8'h09, dummy);
    flush(0, 6);

    // DW=8 word 8'hA5.
    step(1, 1'b1, 8'hA5, dummy);
    flush(1, 10);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) pulse_reset();
      else step(int'($urandom_range(0, 1)), $urandom_range(0, 2) != 0, 8'($urandom), dummy);
    end
    flush(0, 10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
